uc_broadcast_arbiter: RTL and testbench
=======================================

# uc_broadcast_arbiter

Parametrised unit-clause arbiter between NUM_ENGINE BCP engines and the shared unit-clause broadcast bus. Each cycle it grants one engine round-robin and records the implied literal in a per-variable assignment table. It flags a conflict when both polarities of a variable appear, and queues accepted literals in a FIFO for broadcast to all engines. It replaces the fixed 4-engine, non-handshaked arbiter and adds backpressure, fair arbitration and a registered conflict literal.

## Interface
- NUM_VAR, 1024, number of variables; VAR_W = $clog2(NUM_VAR), LIT_W = VAR_W+1
- NUM_ENGINE, 4, engine channels (≥2)
- FIFO_DEPTH, 8, broadcast FIFO entries (power of two, ≥2)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  pulse: clear table/FIFO, begin a new round
- eng_valid  in  NUM_ENGINE  engine e offers a literal
- eng_lit  in  NUM_ENGINE×LIT_W  literal {polarity, var_idx} per engine
- eng_ready  out  NUM_ENGINE  one-hot grant; transfer when eng_valid[e]&eng_ready[e]
- bcast_valid  out  1  FIFO head valid
- bcast_lit  out  LIT_W  FIFO head literal
- bcast_ready  in  1  all engines accept (ANDed outside)
- conflict  out  1  sticky conflict flag
- conflict_lit  out  LIT_W  literal that caused the conflict
- busy  out  1  state==SCAN and (FIFO non-empty or any eng_valid)

## Operation
- States: IDLE (after reset), SCAN, CONFLICT.
  - IDLE→SCAN on start.
  - SCAN→CONFLICT on a conflicting accept.
  - Any state→SCAN on start.
- start, in any state, clears: table, FIFO, conflict, conflict_lit, rr pointer (→0).
- Table: NUM_VAR×2 bits, [var][pol]. Accept of {p,v} sets table[v][p]. If table[v][!p] is already set, it is a conflict: the literal is not pushed, conflict_lit <= literal, state → CONFLICT.
- Arbitration in SCAN: eng_ready is the first engine with eng_valid set, searching from rr_ptr upward with wrap. On accept, rr_ptr <= granted+1 mod NUM_ENGINE. eng_ready is all-zero when FIFO count==FIFO_DEPTH, in IDLE/CONFLICT, or during the start cycle.
- At most one accept per cycle, so the table never sees same-cycle hazards. The table check uses the registered table.
- FIFO: push on non-conflicting accept; pop on bcast_valid&bcast_ready. Simultaneous push and pop when not full keeps count unchanged. Pointers wrap mod FIFO_DEPTH.
- CONFLICT: the FIFO is flushed on entry, bcast_valid=0, conflict=1 until start.

## Timing
- Reset values: eng_ready=0, bcast_valid=0, bcast_lit=0, conflict=0, conflict_lit=0, busy=0, state IDLE, table/FIFO/rr_ptr zeroed.
- eng_ready is combinational from eng_valid, rr_ptr, state and count; there is no path from eng_ready back to eng_valid.
- Accept at cycle N into an empty FIFO → bcast_valid=1 with that literal at N+1.
- Conflicting accept at N → conflict=1 and conflict_lit valid at N+1; bcast_valid=0 from N+1.
- start at N → eng_ready=0 at N; cleared state visible at N+1; first grant possible at N+1.
- Full FIFO with bcast_ready=1 at N → no grant at N; grants resume at N+1.

## Configuration
- UCA_DEDUP_EN defined: an accept whose table[v][p] is already set is acknowledged but not pushed, so each literal is broadcast at most once per round.
- UCA_DEDUP_EN undefined: duplicates are pushed and broadcast; conflict behaviour is unchanged.

## Structure
- uca_pkg holds:
  - uca_state_t enum {IDLE, SCAN, CONFLICT};
  - lit_t packed struct {pol, var_idx};
  - LIT_W helper function.
- Sub-module uca_lit_fifo (parametrised DEPTH, WIDTH; push/pop/flush, full/empty/count).
- The arbiter, table and FSM live in uc_broadcast_arbiter.

## Test plan
- Reset, then start; engines 0 and 2 valid with +5 and +9, bcast_ready=1:
  - grants engine 0 then engine 2;
  - bcast_lit +5 then +9, each one cycle after its accept.
- All 4 engines continuously valid for 8 accepts: grant order 0,1,2,3,0,1,2,3.
- bcast_ready=0, 9 literals offered:
  - 8 accepted;
  - eng_ready=0 while count==8;
  - bcast_ready=1 pops 1, and the next grant comes the following cycle.
- Accept +7, then −7:
  - conflict=1, conflict_lit=−7 next cycle;
  - bcast_valid=0;
  - later start clears conflict and allows a new grant.
- +3 offered twice:
  - with UCA_DEDUP_EN, one broadcast;
  - without it, two broadcasts.
- rst asserted mid-SCAN with 3 queued: all outputs 0 immediately, state IDLE, and no grants until start.

Source files
------------

// File: rtl/uca_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uca_pkg
//  Description : Shared types and helpers for the unit-clause broadcast
//                arbiter (FSM state encoding, literal layout, width helper).
//  Revision    : 1.0 - initial parametrised, handshaked release
// ============================================================================
package uca_pkg;

    // Arbiter control states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SCAN     = 2'd1,
        CONFLICT = 2'd2
    } uca_state_t;

    // Literal layout for the default 1024-variable configuration; the
    // polarity bit is the MSB and is set for a negative literal.
    localparam int UCA_NUM_VAR = 1024;
    localparam int UCA_VAR_W   = $clog2(UCA_NUM_VAR);

    typedef struct packed {
        logic                 pol;
        logic [UCA_VAR_W-1:0] var_idx;
    } lit_t;

    // Literal width for a given variable count: index bits plus polarity
    function automatic int uca_lit_w(input int num_var);
        return $clog2(num_var) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uca_lit_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uca_lit_fifo
//  Description : Power-of-two circular FIFO holding accepted literals awaiting
//                broadcast. Flush has priority over push and pop; a push into
//                a full FIFO and a pop from an empty FIFO are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module uca_lit_fifo
    import uca_pkg::*;
#(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 11,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Storage array: written on an accepted push, no reset needed
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uc_broadcast_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uc_broadcast_arbiter
//  Description : Round-robin arbiter between NUM_ENGINE BCP engines and the
//                shared unit-clause broadcast bus. Accepted literals are
//                recorded in a per-variable polarity table; a literal whose
//                opposite polarity is already recorded raises a sticky
//                conflict. Non-conflicting literals are queued for broadcast.
//                Optional macro UCA_DEDUP_EN: literals already recorded with
//                the same polarity are acknowledged but not re-broadcast.
//  Revision    : 1.0 - parametrised, handshaked, fair arbitration
// ============================================================================
module uc_broadcast_arbiter
    import uca_pkg::*;
#(
    parameter  int NUM_VAR    = 1024,
    parameter  int NUM_ENGINE = 4,
    parameter  int FIFO_DEPTH = 8,
    localparam int VAR_W      = $clog2(NUM_VAR),
    localparam int LIT_W      = uca_lit_w(NUM_VAR)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start_i,
    input  logic [NUM_ENGINE-1:0]            eng_valid_i,
    input  logic [NUM_ENGINE-1:0][LIT_W-1:0] eng_lit_i,
    output logic [NUM_ENGINE-1:0]            eng_ready_o,
    output logic                             bcast_valid_o,
    output logic [LIT_W-1:0]                 bcast_lit_o,
    input  logic                             bcast_ready_i,
    output logic                             conflict_o,
    output logic [LIT_W-1:0]                 conflict_lit_o,
    output logic                             busy_o
);

    localparam int ENG_W = $clog2(NUM_ENGINE);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    uca_state_t                  state_q;
    uca_state_t                  state_d;
    logic [ENG_W-1:0]            rr_q;
    logic [ENG_W-1:0]            rr_d;
    logic [NUM_VAR-1:0][1:0]     tbl_q;
    logic [LIT_W-1:0]            conflict_lit_q;

    logic                        grant_vld;
    logic [ENG_W-1:0]            grant_idx;
    logic                        can_grant;
    logic                        accept;
    logic [LIT_W-1:0]            acc_lit;
    logic                        acc_pol;
    logic [VAR_W-1:0]            acc_var;
    logic                        opp_seen;
    logic                        dup;
    logic                        conflict_acc;
    logic                        fifo_push;
    logic                        fifo_pop;
    logic                        fifo_flush;
    logic [LIT_W-1:0]            fifo_head;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [CNT_W-1:0]            fifo_count;
    logic                        unused_fifo_count;

    // Round-robin search: first valid engine at or after rr_q, with wrap
    always_comb begin
        int j;
        j         = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_ENGINE; k++) begin
            j = int'(rr_q) + k;
            if (j >= NUM_ENGINE) begin
                j = j - NUM_ENGINE;
            end
            if (!grant_vld && eng_valid_i[ENG_W'(j)]) begin
                grant_vld = 1'b1;
                grant_idx = ENG_W'(j);
            end
        end
    end

    // Grants only while scanning, outside a start pulse, with FIFO room.
    // A pop in the same cycle does not free a slot for that cycle's grant.
    assign can_grant = (state_q == SCAN) && !start_i && !fifo_full;
    assign accept    = can_grant && grant_vld;

    assign acc_lit  = eng_lit_i[grant_idx];
    assign acc_pol  = acc_lit[LIT_W-1];
    assign acc_var  = acc_lit[VAR_W-1:0];
    assign opp_seen = tbl_q[acc_var][~acc_pol];

`ifdef UCA_DEDUP_EN
    assign dup = tbl_q[acc_var][acc_pol];
`else
    assign dup = 1'b0;
`endif

    assign conflict_acc = accept && opp_seen;
    assign fifo_push    = accept && !opp_seen && !dup;
    assign fifo_pop     = bcast_valid_o && bcast_ready_i;
    assign fifo_flush   = start_i || conflict_acc;

    // One-hot ready towards the granted engine
    always_comb begin
        eng_ready_o = '0;
        if (accept) begin
            eng_ready_o[grant_idx] = 1'b1;
        end
    end

    // Next state and round-robin pointer
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        if (start_i) begin
            state_d = SCAN;
            rr_d    = '0;
        end else begin
            if (accept) begin
                rr_d = (grant_idx == ENG_W'(NUM_ENGINE - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (conflict_acc) begin
                state_d = CONFLICT;
            end
        end
    end

    // State, pointer and conflict-literal registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            rr_q           <= '0;
            conflict_lit_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            if (start_i) begin
                conflict_lit_q <= '0;
            end else if (conflict_acc) begin
                conflict_lit_q <= acc_lit;
            end
        end
    end

    // Assignment table: marks every accepted literal's polarity
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tbl_q <= '0;
        end else if (start_i) begin
            tbl_q <= '0;
        end else if (accept) begin
            tbl_q[acc_var][acc_pol] <= 1'b1;
        end
    end

    uca_lit_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (LIT_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (fifo_flush),
        .push_i      (fifo_push),
        .push_data_i (acc_lit),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Occupancy is only needed inside the FIFO for full/empty
    assign unused_fifo_count = ^fifo_count;

    assign bcast_valid_o  = !fifo_empty && (state_q != CONFLICT);
    assign bcast_lit_o    = bcast_valid_o ? fifo_head : '0;
    assign conflict_o     = (state_q == CONFLICT);
    assign conflict_lit_o = conflict_lit_q;
    assign busy_o         = (state_q == SCAN) && (!fifo_empty || (|eng_valid_i));

endmodule
`default_nettype wire

// File: tb/tb_uc_broadcast_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uc_broadcast_arbiter
//  Description : Self-checking bench. A queue/associative-array model of the
//                arbiter predicts every output each cycle; directed scenarios
//                are followed by randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uc_broadcast_arbiter;
    import uca_pkg::*;

    localparam int NV = 1024;
    localparam int NE = 4;
    localparam int FD = 8;
    localparam int VW = 10;
    localparam int LW = 11;
`ifdef UCA_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif

    logic                   clk;
    logic                   rst;
    logic                   start;
    logic [NE-1:0]          eng_valid;
    logic [NE-1:0][LW-1:0]  eng_lit;
    logic [NE-1:0]          eng_ready;
    logic                   bcast_valid;
    logic [LW-1:0]          bcast_lit;
    logic                   bcast_ready;
    logic                   conflict;
    logic [LW-1:0]          conflict_lit;
    logic                   busy;

    uc_broadcast_arbiter #(
        .NUM_VAR    (NV),
        .NUM_ENGINE (NE),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start),
        .eng_valid_i    (eng_valid),
        .eng_lit_i      (eng_lit),
        .eng_ready_o    (eng_ready),
        .bcast_valid_o  (bcast_valid),
        .bcast_lit_o    (bcast_lit),
        .bcast_ready_i  (bcast_ready),
        .conflict_o     (conflict),
        .conflict_lit_o (conflict_lit),
        .busy_o         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int             m_mode;     // 0 idle, 1 scanning, 2 conflict
    int             m_q[$];     // literals awaiting broadcast
    bit             m_seen[int];
    int             m_rr;
    int             m_clit;

    // DUT-side observation logs and engine behaviour
    int grant_log[$];
    int bc_log[$];
    int pol_mode;               // 0 drop on grant, 1 hold, 2 reload until limit
    int offered;
    int offer_limit;

    function automatic logic [LW-1:0] mk_lit(input bit neg, input int v);
        lit_t l;
        l.pol     = neg;
        l.var_idx = v[VW-1:0];
        return l;
    endfunction

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    function automatic void model_reset();
        m_mode = 0;
        m_q.delete();
        m_seen.delete();
        m_rr   = 0;
        m_clit = 0;
    endfunction

    task automatic engines_react(input int dg);
        if (dg >= 0) begin
            case (pol_mode)
                0: eng_valid[dg] = 1'b0;
                2: begin
                    if (offered < offer_limit) begin
                        eng_lit[dg] = mk_lit(1'b0, 40 + offered);
                        offered++;
                    end else begin
                        eng_valid[dg] = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    endtask

    // One clock: inputs are already applied at the falling edge.
    task automatic cycle();
        int            g;
        int            dg;
        logic [NE-1:0] er;
        int            o;
        #1;
        if (!rst) model_reset();
        g = -1;
        if (rst && m_mode == 1 && !start && m_q.size() < FD) begin
            for (int k = 0; k < NE; k++) begin
                int e;
                e = (m_rr + k) % NE;
                if (g < 0 && eng_valid[e]) g = e;
            end
        end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("eng_ready",    eng_ready,    er);
        chk("bcast_valid",  bcast_valid,  m_q.size() > 0);
        chk("bcast_lit",    bcast_lit,    m_q.size() > 0 ? m_q[0] : 0);
        chk("conflict",     conflict,     m_mode == 2);
        chk("conflict_lit", conflict_lit, m_clit);
        chk("busy",         busy,         m_mode == 1 && (m_q.size() > 0 || (|eng_valid)));

        dg = -1;
        for (int k = 0; k < NE; k++) begin
            if (eng_ready[k] && eng_valid[k]) dg = k;
        end
        if (dg >= 0) grant_log.push_back(dg);
        if (bcast_valid && bcast_ready) bc_log.push_back(int'(bcast_lit));

        if (rst) begin
            if (start) begin
                model_reset();
                m_mode = 1;
            end else begin
                if (m_q.size() > 0 && bcast_ready) void'(m_q.pop_front());
                if (g >= 0) begin
                    int l;
                    l = int'(eng_lit[g]);
                    o = l ^ (1 << VW);
                    if (m_seen.exists(o)) begin
                        m_mode = 2;
                        m_q.delete();
                        m_clit = l;
                    end else if (!(DEDUP && m_seen.exists(l))) begin
                        m_q.push_back(l);
                    end
                    m_seen[l] = 1'b1;
                    m_rr = (g + 1) % NE;
                end
            end
        end
        @(negedge clk);
        engines_react(dg);
    endtask

    task automatic do_start();
        eng_valid = '0;
        start     = 1'b1;
        cycle();
        start     = 1'b0;
        grant_log.delete();
        bc_log.delete();
    endtask

    initial begin
        int nb;
        rst         = 1'b1;
        start       = 1'b0;
        eng_valid   = '0;
        eng_lit     = '0;
        bcast_ready = 1'b1;
        pol_mode    = 0;
        offered     = 0;
        offer_limit = 0;
        model_reset();
        #2 rst = 1'b0;
        @(negedge clk);
        repeat (2) cycle();             // reset values
        rst = 1'b1;
        eng_valid = 4'b1111;
        repeat (2) cycle();             // IDLE: no grant without start

        // Engines 0 and 2 offer +5 and +9
        do_start();
        pol_mode     = 0;
        eng_lit[0]   = mk_lit(1'b0, 5);
        eng_lit[2]   = mk_lit(1'b0, 9);
        eng_valid    = 4'b0101;
        repeat (4) cycle();
        chk("s1_ngrant", grant_log.size(), 2);
        chk("s1_g0", qget(grant_log, 0), 0);
        chk("s1_g1", qget(grant_log, 1), 2);
        chk("s1_b0", qget(bc_log, 0), int'(mk_lit(1'b0, 5)));
        chk("s1_b1", qget(bc_log, 1), int'(mk_lit(1'b0, 9)));

        // All engines continuously valid
        do_start();
        pol_mode = 1;
        for (int e = 0; e < NE; e++) eng_lit[e] = mk_lit(1'b0, 20 + e);
        eng_valid = 4'b1111;
        repeat (8) cycle();
        chk("s2_ngrant", grant_log.size(), 8);
        for (int i = 0; i < 8; i++) chk("s2_order", qget(grant_log, i), i % NE);
        eng_valid = '0;
        repeat (10) cycle();

        // Backpressure: nine literals into an eight-deep FIFO
        do_start();
        bcast_ready = 1'b0;
        pol_mode    = 2;
        offered     = 4;
        offer_limit = 9;
        for (int e = 0; e < NE; e++) eng_lit[e] = mk_lit(1'b0, 40 + e);
        eng_valid = 4'b1111;
        repeat (10) cycle();
        chk("s3_accepted_full", grant_log.size(), 8);
        bcast_ready = 1'b1;
        cycle();
        chk("s3_no_grant_on_pop", grant_log.size(), 8);
        bcast_ready = 1'b0;
        cycle();
        chk("s3_grant_after_pop", grant_log.size(), 9);
        bcast_ready = 1'b1;
        repeat (12) cycle();
        chk("s3_nbcast", bc_log.size(), 9);
        for (int i = 0; i < 9; i++) chk("s3_bcast_order", qget(bc_log, i), 40 + i);

        // Conflict on +7 / -7
        do_start();
        pol_mode   = 0;
        eng_lit[1] = mk_lit(1'b0, 7);
        eng_valid  = 4'b0010;
        cycle();
        eng_lit[1] = mk_lit(1'b1, 7);
        eng_valid  = 4'b0010;
        cycle();
        #1;
        chk("s4_conflict", conflict, 1'b1);
        chk("s4_conflict_lit", conflict_lit, mk_lit(1'b1, 7));
        chk("s4_bcast_valid", bcast_valid, 1'b0);
        eng_valid = 4'b0001;
        eng_lit[0] = mk_lit(1'b0, 8);
        repeat (3) cycle();
        chk("s4_no_grant_in_conflict", grant_log.size(), 2);
        do_start();
        eng_lit[0] = mk_lit(1'b0, 7);
        eng_valid  = 4'b0001;
        cycle();
        #1;
        chk("s4_conflict_cleared", conflict, 1'b0);
        chk("s4_grant_after_start", qget(grant_log, 0), 0);
        repeat (3) cycle();

        // Duplicate +3
        do_start();
        pol_mode   = 0;
        eng_lit[0] = mk_lit(1'b0, 3);
        eng_valid  = 4'b0001;
        cycle();
        eng_valid  = 4'b0001;
        repeat (5) cycle();
        nb = 0;
        foreach (bc_log[i]) if (bc_log[i] == int'(mk_lit(1'b0, 3))) nb++;
        chk("s5_dup_bcasts", nb, DEDUP ? 1 : 2);
        chk("s5_grants", grant_log.size(), 2);

        // Asynchronous reset with three literals queued
        do_start();
        bcast_ready = 1'b0;
        pol_mode    = 0;
        for (int e = 0; e < 3; e++) eng_lit[e] = mk_lit(1'b0, 60 + e);
        eng_valid = 4'b0111;
        repeat (4) cycle();
        eng_valid = 4'b0111;
        #3 rst = 1'b0;
        #1;
        chk("s6_ready_rst",    eng_ready,    '0);
        chk("s6_bvalid_rst",   bcast_valid,  1'b0);
        chk("s6_blit_rst",     bcast_lit,    '0);
        chk("s6_conflict_rst", conflict,     1'b0);
        chk("s6_clit_rst",     conflict_lit, '0);
        chk("s6_busy_rst",     busy,         1'b0);
        @(negedge clk);
        cycle();
        rst = 1'b1;
        bcast_ready = 1'b1;
        grant_log.delete();
        repeat (3) cycle();
        chk("s6_no_grant_idle", grant_log.size(), 0);
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        chk("s6_grant_after_start", qget(grant_log, 0), 0);

        // Randomized traffic
        pol_mode = 1;
        for (int c = 0; c < 800; c++) begin
            start = ($urandom_range(0, 39) == 0) || (m_mode == 2 && $urandom_range(0, 3) == 0);
            eng_valid = NE'($urandom);
            for (int e = 0; e < NE; e++) eng_lit[e] = mk_lit(1'($urandom_range(0, 1)), $urandom_range(0, 11));
            bcast_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
